// File: rtl/exe_lsu_issue.sv
// exe_lsu_issue: EXE-stage load/store issue unit.
// Holds one memory operation, screens it for alignment and MMU faults, and
// issues it on an SRAM-like req/addr_ok/data_ok bus. In-flight requests are
// tracked in order so responses can be aligned/extended, or dropped after a flush.
// Optional build macro EXE_LSU_PERF_EN adds load/store/stall performance counters.
module exe_lsu_issue #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_load,
  input  logic                    in_store,
  input  logic [1:0]              in_size,
  input  logic                    in_unsigned,
  input  logic [31:0]             in_addr,
  input  logic [DATA_WIDTH-1:0]   in_wdata,
  input  logic                    in_mmu_excp,
  input  logic                    flush,
  output logic                    done_valid,
  output logic                    done_ale,
  output logic                    req,
  output logic                    wr,
  output logic [1:0]              size,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [31:0]             addr,
  output logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    addr_ok,
  input  logic                    data_ok,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rsp_valid,
  output logic                    rsp_load,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    busy
`ifdef EXE_LSU_PERF_EN
  ,
  output logic [31:0]             perf_ld_cnt,
  output logic [31:0]             perf_st_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PTR_W = $clog2(OUTSTANDING);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                  state_reg;
  logic                    load_reg, store_reg, unsigned_reg;
  logic [1:0]              size_reg;
  logic [31:0]             addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic                    done_valid_reg, done_ale_reg;

  // In-flight FIFO: per-entry response formatting info plus a cancel flag.
  logic                    ent_load_reg     [OUTSTANDING];
  logic                    ent_unsigned_reg [OUTSTANDING];
  logic [1:0]              ent_size_reg     [OUTSTANDING];
  logic [OFF_W-1:0]        ent_off_reg      [OUTSTANDING];
  logic [OUTSTANDING-1:0]  ent_cancel;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]          count_reg;

  logic                    rsp_valid_reg, rsp_load_reg;
  logic [DATA_WIDTH-1:0]   rsp_data_reg;

  logic                    accept, full, push, pop;
  logic [2:0]              in_mask;
  logic                    in_misaligned, in_mem, in_fault;

  assign in_ready      = (state_reg == IDLE);
  assign accept        = in_valid & in_ready;
  assign in_mask       = 3'((4'd1 << in_size) - 4'd1);
  assign in_misaligned = |(in_addr[2:0] & in_mask);
  assign in_mem        = in_load | in_store;
  assign in_fault      = in_mmu_excp | in_misaligned;

  assign full = (count_reg == (PTR_W+1)'(OUTSTANDING));
  assign req  = (state_reg == ISSUE) & ~full & ~flush;
  assign push = req & addr_ok;
  assign pop  = data_ok & (count_reg != '0);
  assign busy = (count_reg != '0);

  // Fault/non-memory ops complete from a register; issued ops complete on addr_ok.
  assign done_valid = done_valid_reg | push;
  assign done_ale   = done_ale_reg;

  // Operation FSM: latch the offered operation, then hold it until the bus takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      load_reg       <= 1'b0;
      store_reg      <= 1'b0;
      unsigned_reg   <= 1'b0;
      size_reg       <= 2'd0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      done_valid_reg <= 1'b0;
      done_ale_reg   <= 1'b0;
    end else begin
      done_valid_reg <= 1'b0;
      done_ale_reg   <= 1'b0;
      if (flush) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              load_reg     <= in_load;
              store_reg    <= in_store;
              unsigned_reg <= in_unsigned;
              size_reg     <= in_size;
              addr_reg     <= in_addr;
              wdata_reg    <= in_wdata;
              if (!in_mem || in_fault) begin
                done_valid_reg <= 1'b1;
                done_ale_reg   <= in_mem & in_misaligned & ~in_mmu_excp;
              end else begin
                state_reg <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (push) state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // FIFO pointers, occupancy and entry payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        ent_load_reg[wr_ptr_reg]     <= load_reg;
        ent_unsigned_reg[wr_ptr_reg] <= unsigned_reg;
        ent_size_reg[wr_ptr_reg]     <= size_reg;
        ent_off_reg[wr_ptr_reg]      <= addr_reg[OFF_W-1:0];
        wr_ptr_reg                   <= wr_ptr_reg + 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUTSTANDING; gi++) begin : g_cancel
      logic cancel_reg;
      // A flush marks every entry stale; a fresh push (never in a flush cycle) clears it.
      always_ff @(posedge clk) begin
        if (reset)
          cancel_reg <= 1'b0;
        else if (flush)
          cancel_reg <= 1'b1;
        else if (push && wr_ptr_reg == PTR_W'(gi))
          cancel_reg <= 1'b0;
      end
      assign ent_cancel[gi] = cancel_reg;
    end
  endgenerate

  // Request side: store strobes and replicated store data.
  logic [OFF_W-1:0] req_off;
  logic [OFF_W-1:0] req_size_mask;
  logic [3:0]       req_nbytes;

  assign req_off       = addr_reg[OFF_W-1:0];
  assign req_nbytes    = 4'd1 << size_reg;
  assign req_size_mask = OFF_W'(req_nbytes - 4'd1);
  assign wr            = store_reg;
  assign size          = size_reg;
  assign addr          = addr_reg;

  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_req_byte
      logic [OFF_W-1:0] src_idx;
      assign src_idx  = OFF_W'(gi) & req_size_mask;
      assign wstrb[gi] = store_reg && (gi >= int'(req_off)) &&
                         (gi < int'(req_off) + int'(req_nbytes));
      assign wdata[gi*8 +: 8] = wdata_reg[{src_idx, 3'b000} +: 8];
    end
  endgenerate

  // Response side: align the head entry's bytes down, then sign/zero extend.
  logic                  head_load, head_unsigned, head_cancel;
  logic [1:0]            head_size;
  logic [OFF_W-1:0]      head_off;
  logic [DATA_WIDTH-1:0] shifted, rsp_ext;
  logic                  sign_bit, fill;

  assign head_load     = ent_load_reg[rd_ptr_reg];
  assign head_unsigned = ent_unsigned_reg[rd_ptr_reg];
  assign head_size     = ent_size_reg[rd_ptr_reg];
  assign head_off      = ent_off_reg[rd_ptr_reg];
  assign head_cancel   = ent_cancel[rd_ptr_reg];
  assign shifted       = rdata >> {head_off, 3'b000};

  // Pick the sign bit of the accessed width.
  always_comb begin
    sign_bit = shifted[DATA_WIDTH-1];
    case (head_size)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_WIDTH-1];
    endcase
    fill = sign_bit & ~head_unsigned;
  end

  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_rsp_byte
      assign rsp_ext[gi*8 +: 8] = (gi < int'(4'd1 << head_size)) ?
                                  shifted[gi*8 +: 8] : {8{fill}};
    end
  endgenerate

  // Registered response; cancelled heads and flush-cycle pops are swallowed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_load_reg  <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      rsp_valid_reg <= pop & ~head_cancel & ~flush;
      rsp_load_reg  <= pop & ~head_cancel & ~flush & head_load;
      rsp_data_reg  <= (pop && !head_cancel && !flush && head_load) ? rsp_ext : '0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_load  = rsp_load_reg;
  assign rsp_data  = rsp_data_reg;

`ifdef EXE_LSU_PERF_EN
  logic [31:0] perf_ld_reg, perf_st_reg, perf_stall_reg;

  // Event counters: accepted loads/stores and cycles waiting on addr_ok.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ld_reg    <= '0;
      perf_st_reg    <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (accept && !flush && in_load)  perf_ld_reg    <= perf_ld_reg + 32'd1;
      if (accept && !flush && in_store) perf_st_reg    <= perf_st_reg + 32'd1;
      if (req && !addr_ok)              perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_ld_cnt    = perf_ld_reg;
  assign perf_st_cnt    = perf_st_reg;
  assign perf_stall_cnt = perf_stall_reg;
`endif

endmodule

// File: tb/tb_exe_lsu_issue.sv
// Testbench for exe_lsu_issue (DATA_WIDTH=32, OUTSTANDING=2): directed
// scenarios followed by randomized traffic, all compared every cycle against
// a queue-based behavioural model of the unit.
module tb_exe_lsu_issue;
  localparam int DW  = 32;
  localparam int OUT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_load, in_store, in_unsigned, in_mmu_excp;
  logic [1:0]    in_size;
  logic [31:0]   in_addr;
  logic [DW-1:0] in_wdata;
  logic          flush, done_valid, done_ale, req, wr;
  logic [1:0]    size;
  logic [DW/8-1:0] wstrb;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          addr_ok, data_ok;
  logic [DW-1:0] rdata;
  logic          rsp_valid, rsp_load;
  logic [DW-1:0] rsp_data;
  logic          busy;

  always #5 clk = ~clk;

  exe_lsu_issue #(.DATA_WIDTH(DW), .OUTSTANDING(OUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_mmu_excp(in_mmu_excp), .flush(flush),
    .done_valid(done_valid), .done_ale(done_ale),
    .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_load(rsp_load), .rsp_data(rsp_data), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit       load;
    bit [1:0] sz;
    bit       uns;
    bit [1:0] off;
    bit       cancel;
  } ent_t;

  ent_t      q[$];
  bit        m_issue;
  bit        m_load, m_store, m_uns;
  bit [1:0]  m_size;
  bit [31:0] m_addr, m_wdata;
  bit        m_done, m_ale;
  bit        m_rsp, m_rsp_load;
  bit [31:0] m_rsp_data;

  task automatic model_reset();
    q.delete();
    m_issue = 0; m_load = 0; m_store = 0; m_uns = 0; m_size = 0;
    m_addr = 0; m_wdata = 0; m_done = 0; m_ale = 0;
    m_rsp = 0; m_rsp_load = 0; m_rsp_data = 0;
  endtask

  function automatic logic [3:0] exp_strb(bit st, bit [1:0] sz, bit [31:0] a);
    int n = 1 << sz;
    if (!st) return 4'h0;
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] exp_wdata(bit [1:0] sz, bit [31:0] wd);
    int n = 1 << sz;
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_ext(bit [31:0] rd, bit [1:0] off, bit [1:0] sz, bit uns);
    longint unsigned v = 64'(rd) >> (8 * off);
    int nb = 8 << sz;
    longint unsigned mask;
    if (nb >= 32) return v[31:0];
    mask = (64'd1 << nb) - 1;
    v = v & mask;
    if (!uns && v[nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model, then advance the model and clock.
  task automatic cycle();
    bit   e_req, push, was_issue, mis, mem;
    ent_t e;
    #1;
    e_req = m_issue && (q.size() < OUT) && !flush;
    check("in_ready", 32'(in_ready), 32'(!m_issue));
    check("req", 32'(req), 32'(e_req));
    if (e_req) begin
      check("wr", 32'(wr), 32'(m_store));
      check("size", 32'(size), 32'(m_size));
      check("addr", addr, m_addr);
      check("wstrb", 32'(wstrb), 32'(exp_strb(m_store, m_size, m_addr)));
      if (m_store) check("wdata", wdata, exp_wdata(m_size, m_wdata));
    end
    check("done_valid", 32'(done_valid), 32'(m_done || (e_req && addr_ok)));
    if (m_done) check("done_ale", 32'(done_ale), 32'(m_ale));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    if (m_rsp) begin
      check("rsp_load", 32'(rsp_load), 32'(m_rsp_load));
      check("rsp_data", rsp_data, m_rsp_data);
    end
    check("busy", 32'(busy), 32'(q.size() != 0));

    // model state as of the coming edge
    if (reset) begin
      model_reset();
    end else begin
      push      = e_req && addr_ok;
      was_issue = m_issue;
      m_rsp = 0; m_rsp_load = 0; m_rsp_data = 0;
      if (data_ok && q.size() > 0) begin
        e = q.pop_front();
        if (!e.cancel && !flush) begin
          m_rsp      = 1;
          m_rsp_load = e.load;
          m_rsp_data = e.load ? exp_ext(rdata, e.off, e.sz, e.uns) : 32'h0;
        end
      end
      m_done = 0; m_ale = 0;
      if (push) begin
        e.load = m_load; e.sz = m_size; e.uns = m_uns; e.off = m_addr[1:0]; e.cancel = 0;
        q.push_back(e);
        m_issue = 0;
      end
      if (flush) begin
        foreach (q[i]) q[i].cancel = 1;
        m_issue = 0;
      end else if (!was_issue && in_valid) begin
        mis = (in_addr % (32'd1 << in_size)) != 0;
        mem = in_load || in_store;
        if (!mem || in_mmu_excp || mis) begin
          m_done = 1;
          m_ale  = mem && mis && !in_mmu_excp;
        end else begin
          m_issue = 1;
          m_load = in_load; m_store = in_store; m_uns = in_unsigned;
          m_size = in_size; m_addr = in_addr; m_wdata = in_wdata;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_valid = 0; addr_ok = 0; data_ok = 0; flush = 0;
  endtask

  task automatic offer(bit ld, bit st, bit [1:0] sz, bit uns, bit [31:0] a, bit [31:0] wd, bit mmu);
    in_valid = 1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
    in_addr = a; in_wdata = wd; in_mmu_excp = mmu;
    cycle();
    in_valid = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; in_valid = 0; in_load = 0; in_store = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_wdata = 0; in_mmu_excp = 0; flush = 0; addr_ok = 0; data_ok = 0; rdata = 0;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    // reset state
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_req", 32'(req), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wstrb", 32'(wstrb), 32'd0);
    reset = 0;
    cycle();

    // word load, addr_ok in 2nd req cycle
    offer(1, 0, 2, 0, 32'h1C00_0004, 0, 0);
    check("wl_req_rise", 32'(req), 32'd1);
    cycle();
    addr_ok = 1;
    cycle();
    addr_ok = 0;
    check("wl_back_idle", 32'(in_ready), 32'd1);
    data_ok = 1; rdata = 32'h8000_0001;
    cycle();
    data_ok = 0;
    check("wl_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wl_rsp_data", rsp_data, 32'h8000_0001);
    check("wl_rsp_load", 32'(rsp_load), 32'd1);
    cycle();

    // signed and unsigned byte load at offset 3
    for (int u = 0; u < 2; u++) begin
      offer(1, 0, 0, u[0], 32'h1C00_0003, 0, 0);
      addr_ok = 1;
      cycle();
      addr_ok = 0;
      data_ok = 1; rdata = 32'h8A00_0000;
      cycle();
      data_ok = 0;
      check("byte_ld_data", rsp_data, (u == 0) ? 32'hFFFF_FF8A : 32'h0000_008A);
    end

    // half store at offset 2
    offer(0, 1, 1, 0, 32'h1C00_0002, 32'h0000_1234, 0);
    check("hs_wstrb", 32'(wstrb), 32'hC);
    check("hs_wdata", wdata, 32'h1234_1234);
    check("hs_wr", 32'(wr), 32'd1);
    addr_ok = 1;
    cycle();
    addr_ok = 0;
    data_ok = 1; rdata = 32'hDEAD_BEEF;
    cycle();
    data_ok = 0;
    check("hs_rsp_load", 32'(rsp_load), 32'd0);
    check("hs_rsp_data", rsp_data, 32'd0);

    // misaligned word load, without and with MMU exception
    offer(1, 0, 2, 0, 32'h1C00_0002, 0, 0);
    check("ale_done", 32'(done_valid), 32'd1);
    check("ale_flag", 32'(done_ale), 32'd1);
    check("ale_no_req", 32'(req), 32'd0);
    offer(1, 0, 2, 0, 32'h1C00_0002, 0, 1);
    check("mmu_done", 32'(done_valid), 32'd1);
    check("mmu_ale", 32'(done_ale), 32'd0);
    cycle();

    // outstanding limit: two in flight, third held until a data_ok
    for (int k = 0; k < 2; k++) begin
      offer(1, 0, 2, 0, 32'h1C00_0010 + 32'(4*k), 0, 0);
      addr_ok = 1;
      cycle();
      addr_ok = 0;
    end
    offer(1, 0, 2, 0, 32'h1C00_0020, 0, 0);
    addr_ok = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("full_no_done", 32'(done_valid), 32'd0);
    end
    data_ok = 1; rdata = 32'h1111_1111;
    cycle();
    data_ok = 0;
    cycle();
    addr_ok = 0;
    for (int k = 0; k < 3; k++) begin
      data_ok = 1; rdata = 32'h2222_0000 + 32'(k);
      cycle();
    end
    data_ok = 0;
    cycle();
    check("drain_busy", 32'(busy), 32'd0);

    // flush with two loads in flight drops both responses
    for (int k = 0; k < 2; k++) begin
      offer(1, 0, 2, 0, 32'h1C00_0030 + 32'(4*k), 0, 0);
      addr_ok = 1;
      cycle();
      addr_ok = 0;
    end
    flush = 1;
    cycle();
    flush = 0;
    for (int k = 0; k < 2; k++) begin
      data_ok = 1; rdata = 32'h5555_5555;
      cycle();
      check("flush_drop", 32'(rsp_valid), 32'd0);
    end
    data_ok = 0;
    offer(1, 0, 2, 0, 32'h1C00_0040, 0, 0);
    addr_ok = 1;
    cycle();
    addr_ok = 0;
    data_ok = 1; rdata = 32'h7654_3210;
    cycle();
    data_ok = 0;
    check("post_flush_valid", 32'(rsp_valid), 32'd1);
    check("post_flush_data", rsp_data, 32'h7654_3210);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit [31:0] a;
      bit [1:0]  sz;
      sz = 2'($urandom_range(0, 2));
      a  = 32'h1C00_0000 | ($urandom & 32'hFF);
      if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 1);
      in_valid    = ($urandom_range(0, 1) == 1);
      in_load     = 0; in_store = 0;
      case ($urandom_range(0, 9))
        0:       ;
        1, 2, 3: in_store = 1;
        default: in_load = 1;
      endcase
      in_size     = sz;
      in_unsigned = $urandom_range(0, 1) == 1;
      in_addr     = a;
      in_wdata    = $urandom;
      in_mmu_excp = ($urandom_range(0, 9) == 0);
      addr_ok     = ($urandom_range(0, 1) == 1);
      data_ok     = ($urandom_range(0, 9) < 4);
      rdata       = $urandom;
      flush       = ($urandom_range(0, 29) == 0);
      cycle();
    end

    // drain everything still held or in flight
    quiet();
    addr_ok = 1; data_ok = 1;
    for (int n = 0; n < 12; n++) begin
      rdata = $urandom;
      cycle();
    end
    quiet();
    cycle();
    check("final_busy", 32'(busy), 32'd0);
    check("final_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
